tsm_hst_arb: RTL and testbench

Two-requester arbiter and access sequencer for the filter system-register host port. It sits between a host APB bridge (requester 0) and an on-chip config/statistics poller (requester 1), and drives the shared hst_* strobe bus of the MAC-filter register block. It serialises accesses with round-robin fairness, generates the setup/enable phasing the register block expects, and returns read data with a completion pulse.

---
 rtl/tsm_hst_arb.sv | 151 +++++++++++++++
 tb/tb_tsm_hst_arb.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsm_hst_arb.sv
// Round-robin arbiter and setup/enable sequencer for the filter register host port.
// Define TSM_HSTARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC cycles without pready.
module tsm_hst_arb #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        hst_clk_i,
    input  logic        hst_rst_ni,
    input  logic        r0_req_i,
    input  logic        r0_wr_i,
    input  logic [4:0]  r0_addr_i,
    input  logic [31:0] r0_wdat_i,
    output logic        r0_gnt_o,
    output logic        r0_done_o,
    output logic [31:0] r0_rdat_o,
    output logic        r0_err_o,
    input  logic        r1_req_i,
    input  logic        r1_wr_i,
    input  logic [4:0]  r1_addr_i,
    input  logic [31:0] r1_wdat_i,
    output logic        r1_gnt_o,
    output logic        r1_done_o,
    output logic [31:0] r1_rdat_o,
    output logic        r1_err_o,
    output logic        hst_csn_o,
    output logic        hst_wrn_o,
    output logic        hst_pen_o,
    output logic [4:0]  hst_addr_o,
    output logic [31:0] hst_wdat_o,
    input  logic [31:0] hst_rdat_i,
    input  logic        hst_pready_i
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_cfg_err
        $error("tsm_hst_arb: TIMEOUT_CYC must be 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic        last_q;
    logic        owner_q;
    logic        wr_q;
    logic [4:0]  addr_q;
    logic [31:0] wdat_q;
    logic [31:0] rdat0_q, rdat1_q;
    logic        idle;
    logic        gnt0, gnt1;
    logic        to_hit;
    logic        finish;

    // Grants are gated with reset so every output reads 0 while held in reset.
    assign idle = (state_q == IDLE) && hst_rst_ni;
    assign gnt0 = idle && r0_req_i && (!r1_req_i || last_q);
    assign gnt1 = idle && r1_req_i && (!r0_req_i || !last_q);

`ifdef TSM_HSTARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q;

    always_ff @(posedge hst_clk_i or negedge hst_rst_ni) begin
        if (!hst_rst_ni) begin
            cnt_q <= 8'd0;
        end else if (state_q != ACCESS) begin
            cnt_q <= 8'd0;
        end else if (!hst_pready_i) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // A pready landing on the limit cycle still wins.
    assign to_hit = (state_q == ACCESS) && !hst_pready_i
                    && (cnt_q == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge hst_clk_i or negedge hst_rst_ni) begin
        if (!hst_rst_ni) begin
            err_q <= 1'b0;
        end else if (finish) begin
            err_q <= to_hit;
        end
    end

    assign r0_err_o = r0_done_o && err_q;
    assign r1_err_o = r1_done_o && err_q;
`else
    assign to_hit   = 1'b0;
    assign r0_err_o = 1'b0;
    assign r1_err_o = 1'b0;
`endif

    assign finish = (state_q == ACCESS) && (hst_pready_i || to_hit);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt0 || gnt1) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (finish) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hst_clk_i or negedge hst_rst_ni) begin
        if (!hst_rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 5'd0;
            wdat_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (gnt0 || gnt1) begin
                owner_q <= gnt1;
                last_q  <= gnt1;
                wr_q    <= gnt1 ? r1_wr_i   : r0_wr_i;
                addr_q  <= gnt1 ? r1_addr_i : r0_addr_i;
                wdat_q  <= gnt1 ? r1_wdat_i : r0_wdat_i;
            end
        end
    end

    // Read data goes straight to the owner's holding register.
    always_ff @(posedge hst_clk_i or negedge hst_rst_ni) begin
        if (!hst_rst_ni) begin
            rdat0_q <= 32'd0;
            rdat1_q <= 32'd0;
        end else if (finish) begin
            if (owner_q) rdat1_q <= to_hit ? 32'd0 : hst_rdat_i;
            else         rdat0_q <= to_hit ? 32'd0 : hst_rdat_i;
        end
    end

    assign r0_gnt_o   = gnt0;
    assign r1_gnt_o   = gnt1;
    assign r0_done_o  = (state_q == DONE) && !owner_q;
    assign r1_done_o  = (state_q == DONE) && owner_q;
    assign r0_rdat_o  = rdat0_q;
    assign r1_rdat_o  = rdat1_q;
    assign hst_csn_o  = (state_q == SETUP) || (state_q == ACCESS);
    assign hst_pen_o  = (state_q == ACCESS);
    assign hst_wrn_o  = wr_q;
    assign hst_addr_o = addr_q;
    assign hst_wdat_o = wdat_q;

endmodule

// File: tb/tb_tsm_hst_arb.sv
// Bench for tsm_hst_arb: directed cases plus randomized traffic against a
// transaction-level model (winner rule, fixed phase latency, per-requester read data).
module tb_tsm_hst_arb;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req [2];
    logic        wr  [2];
    logic [4:0]  addr[2];
    logic [31:0] wdat[2];
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] rdat0, rdat1;
    logic        csn, wrn, pen;
    logic [4:0]  b_addr;
    logic [31:0] b_wdat;
    logic [31:0] b_rdat = 32'd0;
    logic        pready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic        last_m;
    logic [31:0] rdat_m[2];
    logic        bwr_m;
    logic [4:0]  baddr_m;
    logic [31:0] bwdat_m;
    int          wins[$];

    always #5 clk = ~clk;

    tsm_hst_arb #(.TIMEOUT_CYC(TO)) dut (
        .hst_clk_i   (clk),
        .hst_rst_ni  (rst_n),
        .r0_req_i    (req[0]),
        .r0_wr_i     (wr[0]),
        .r0_addr_i   (addr[0]),
        .r0_wdat_i   (wdat[0]),
        .r0_gnt_o    (gnt0),
        .r0_done_o   (done0),
        .r0_rdat_o   (rdat0),
        .r0_err_o    (err0),
        .r1_req_i    (req[1]),
        .r1_wr_i     (wr[1]),
        .r1_addr_i   (addr[1]),
        .r1_wdat_i   (wdat[1]),
        .r1_gnt_o    (gnt1),
        .r1_done_o   (done1),
        .r1_rdat_o   (rdat1),
        .r1_err_o    (err1),
        .hst_csn_o   (csn),
        .hst_wrn_o   (wrn),
        .hst_pen_o   (pen),
        .hst_addr_o  (b_addr),
        .hst_wdat_o  (b_wdat),
        .hst_rdat_i  (b_rdat),
        .hst_pready_i(pready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        last_m    = 1'b1;
        rdat_m[0] = 32'd0;
        rdat_m[1] = 32'd0;
        bwr_m     = 1'b0;
        baddr_m   = 5'd0;
        bwdat_m   = 32'd0;
    endtask

    task automatic new_cmd(input int i);
        req[i]  = 1'b1;
        wr[i]   = 1'($urandom);
        addr[i] = 5'($urandom);
        wdat[i] = $urandom;
    endtask

    task automatic chk_bus(input string tag);
        chk1({tag, "_wrn"}, wrn, bwr_m);
        chk({tag, "_addr"}, 32'(b_addr), 32'(baddr_m));
        chk({tag, "_wdat"}, b_wdat, bwdat_m);
    endtask

    // Caller has already raised req for this cycle (cycle 0, IDLE).
    task automatic run_access(input int d, input bit spur, input bit fix,
                              input logic [31:0] rfix, output int w);
        logic [31:0] rd;
        rd = 32'd0;
        if (req[0] && req[1]) w = last_m ? 0 : 1;
        else                  w = req[1] ? 1 : 0;
        @(negedge clk);
        chk1("c0_gnt0", gnt0, w == 0);
        chk1("c0_gnt1", gnt1, w == 1);
        chk1("c0_csn", csn, 1'b0);
        chk_bus("c0_hold");
        last_m  = w[0];
        bwr_m   = wr[w];
        baddr_m = addr[w];
        bwdat_m = wdat[w];
        cyc();
        req[w] = 1'b0;
        pready = spur;
        @(negedge clk);
        chk1("setup_csn", csn, 1'b1);
        chk1("setup_pen", pen, 1'b0);
        chk1("setup_gnt", gnt0 | gnt1, 1'b0);
        chk1("setup_done", done0 | done1, 1'b0);
        chk_bus("setup");
        for (int k = 0; k <= d; k++) begin
            cyc();
            pready = (k == d);
            rd     = fix ? rfix : $urandom;
            b_rdat = rd;
            @(negedge clk);
            chk1("acc_csn", csn, 1'b1);
            chk1("acc_pen", pen, 1'b1);
            chk1("acc_done", done0 | done1, 1'b0);
            chk1("acc_gnt", gnt0 | gnt1, 1'b0);
        end
        cyc();
        pready    = 1'b0;
        b_rdat    = $urandom;
        rdat_m[w] = rd;
        @(negedge clk);
        chk1("done0", done0, w == 0);
        chk1("done1", done1, w == 1);
        chk1("done_err", err0 | err1, 1'b0);
        chk("rdat0", rdat0, rdat_m[0]);
        chk("rdat1", rdat1, rdat_m[1]);
        chk1("done_csn", csn | pen, 1'b0);
        chk1("done_gnt", gnt0 | gnt1, 1'b0);
        chk_bus("done");
    endtask

    task automatic chk_reset_outs(input string tag);
        chk1({tag, "_csn"}, csn, 1'b0);
        chk1({tag, "_pen"}, pen, 1'b0);
        chk1({tag, "_done"}, done0 | done1, 1'b0);
        chk1({tag, "_err"}, err0 | err1, 1'b0);
        chk1({tag, "_gnt"}, gnt0 | gnt1, 1'b0);
        chk({tag, "_rdat0"}, rdat0, 32'd0);
        chk({tag, "_rdat1"}, rdat1, 32'd0);
        chk_bus(tag);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; addr[i] = 5'd0; wdat[i] = 32'd0;
        end
        model_reset();
        #2;
        chk_reset_outs("rst");
        cyc();
        cyc();
        rst_n = 1'b1;

        // r0 write 0x15 / 0xA56, pready in first ACCESS cycle
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 5'h15; wdat[0] = 32'h0000_0A56;
        run_access(0, 1'b0, 1'b0, 32'd0, w);
        chk("t1_winner", 32'(w), 32'd0);

        // r1 read 0x16 returning 7; bus still holds the write at cycle 5
        cyc();
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 5'h16; wdat[1] = 32'h1234_5678;
        run_access(0, 1'b0, 1'b1, 32'h0000_0007, w);
        chk("t2_r1_rdat", rdat1, 32'h0000_0007);

        // continuous contention alternates starting with r0
        wins.delete();
        new_cmd(0);
        new_cmd(1);
        for (int n = 0; n < 4; n++) begin
            cyc();
            if (!req[0]) new_cmd(0);
            if (!req[1]) new_cmd(1);
            run_access(n % 2, 1'b0, 1'b0, 32'd0, w);
            wins.push_back(w);
        end
        for (int n = 0; n < 4; n++) chk("rr_seq", 32'(wins[n]), 32'(n % 2));

        // spurious pready while idle
        cyc();
        req[0] = 1'b0; req[1] = 1'b0;
        pready = 1'b1;
        @(negedge clk);
        chk1("spur_idle_csn", csn, 1'b0);
        cyc();
        pready = 1'b0;
        @(negedge clk);
        chk1("spur_idle_done", done0 | done1, 1'b0);
        chk1("spur_idle_csn2", csn, 1'b0);

        // randomized traffic with gaps, spurious pready and variable latency
        for (int t = 0; t < 40; t++) begin
            if (!req[0] && !req[1] && $urandom_range(0, 3) == 0) begin
                cyc();
                pready = 1'($urandom);
                @(negedge clk);
                chk1("gap_gnt", gnt0 | gnt1, 1'b0);
                chk1("gap_csn", csn, 1'b0);
                chk_bus("gap");
                cyc();
                pready = 1'b0;
                @(negedge clk);
                chk1("gap_done", done0 | done1, 1'b0);
            end
            cyc();
            for (int i = 0; i < 2; i++)
                if (!req[i] && $urandom_range(0, 1) == 1) new_cmd(i);
            if (!req[0] && !req[1]) new_cmd($urandom_range(0, 1));
            run_access($urandom_range(0, 3), 1'($urandom), 1'b0, 32'd0, w);
        end

        // reset in the middle of an access
        cyc();
        req[0] = 1'b0;
        if (!req[1]) new_cmd(1);
        run_access(0, 1'b0, 1'b0, 32'd0, w);
        cyc();
        new_cmd(0);
        @(negedge clk);
        w = gnt1 ? 1 : 0;
        cyc();
        req[w] = 1'b0;
        cyc();
        @(negedge clk);
        chk1("pre_rst_pen", pen, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_outs("mid_rst");
        req[0] = 1'b1;
        req[1] = 1'b1;
        cyc();
        @(negedge clk);
        chk_reset_outs("mid_rst_hold");
        cyc();
        rst_n = 1'b1;
        run_access(1, 1'b0, 1'b0, 32'd0, w);
        chk("post_rst_tie", 32'(w), 32'd0);
        cyc();
        run_access(0, 1'b0, 1'b0, 32'd0, w);
        chk("post_rst_next", 32'(w), 32'd1);

`ifdef TSM_HSTARB_TIMEOUT_EN
        // pready on the limit cycle is a success
        cyc();
        new_cmd(0);
        run_access(TO - 1, 1'b0, 1'b0, 32'd0, w);
        // no pready: abort after TO ACCESS cycles
        cyc();
        new_cmd(1);
        @(negedge clk);
        chk1("to_gnt1", gnt1, 1'b1);
        cyc();
        req[1] = 1'b0;
        b_rdat = 32'hDEAD_BEEF;
        for (int k = 0; k <= TO; k++) begin
            cyc();
            @(negedge clk);
            chk1("to_pen", pen, k < TO);
            chk1("to_done1", done1, k == TO);
            chk1("to_err1", err1, k == TO);
        end
        chk("to_rdat1", rdat1, 32'd0);
        chk1("to_err0", err0, 1'b0);
`else
        // without timeout ACCESS waits forever
        cyc();
        new_cmd(1);
        @(negedge clk);
        chk1("nto_gnt1", gnt1, 1'b1);
        cyc();
        req[1] = 1'b0;
        for (int k = 0; k < 101; k++) begin
            cyc();
            @(negedge clk);
            chk1("nto_done", done0 | done1, 1'b0);
            chk1("nto_err", err0 | err1, 1'b0);
        end
        chk1("nto_pen", pen, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset_outs("nto_rst");
        cyc();
        rst_n = 1'b1;
`endif

        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
